// File: rtl/eco32f_wb.sv
// eco32f_wb: write-back stage with exception capture and pipeline flush sequencing
module eco32f_wb #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  logic        mem_valid,
    input  logic        mem_op_load,
    input  logic        mem_rf_we,
    input  logic [4:0]  mem_rf_dst,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_lsu_result,
    input  logic [31:0] mem_lsu_addr,
    input  logic [31:0] mem_pc,
    input  logic        mem_exc_dtlb_umiss,
    input  logic        mem_exc_dtlb_kmiss,
    input  logic        mem_exc_dtlb_invalid,
    input  logic        mem_exc_dtlb_write,
    input  logic        mem_exc_bus,
    output logic        wb_rf_we,
    output logic [4:0]  wb_rf_dst,
    output logic [31:0] wb_rf_result,
    output logic        wb_exc,
    output logic [4:0]  wb_exc_code,
    output logic        wb_exc_umiss,
    output logic [31:0] wb_exc_pc,
    output logic [31:0] wb_bad_addr,
    output logic        pipeline_flush
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state;
    logic [2:0] cnt;
    logic retire, exc_any, is_umiss;
    logic [4:0] code;
    // an instruction retires only when the slot is real, not stalled and not being flushed
    assign retire   = !mem_stall && mem_valid && !pipeline_flush;
    assign exc_any  = mem_exc_bus || mem_exc_dtlb_kmiss || mem_exc_dtlb_umiss || mem_exc_dtlb_write || mem_exc_dtlb_invalid;
    assign is_umiss = mem_exc_dtlb_umiss && !mem_exc_bus && !mem_exc_dtlb_kmiss;
    // exception priority: bus > kernel miss > user miss > write > invalid
    always_comb code = mem_exc_bus ? 5'd16 : (mem_exc_dtlb_kmiss || mem_exc_dtlb_umiss) ? 5'd21 : mem_exc_dtlb_write ? 5'd22 : 5'd23;
    // stage register, exception capture and flush sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            cnt            <= '0;
            wb_rf_we       <= 1'b0;
            wb_rf_dst      <= '0;
            wb_rf_result   <= '0;
            wb_exc         <= 1'b0;
            wb_exc_code    <= '0;
            wb_exc_umiss   <= 1'b0;
            wb_exc_pc      <= '0;
            wb_bad_addr    <= '0;
            pipeline_flush <= 1'b0;
        end else begin
            wb_rf_we <= retire && !exc_any && mem_rf_we && mem_rf_dst != 5'd0;
            wb_exc   <= retire && exc_any;
            if (retire && !exc_any) begin
                wb_rf_dst    <= mem_rf_dst;
                wb_rf_result <= mem_op_load ? mem_lsu_result : mem_alu_result;
            end
            if (retire && exc_any) begin
                wb_exc_code  <= code;
                wb_exc_umiss <= is_umiss;
                wb_exc_pc    <= mem_pc;
                wb_bad_addr  <= mem_lsu_addr;
            end
            case (state)
                RUN: if (retire && exc_any) begin
                    state          <= FLUSH;
                    cnt            <= 3'(FLUSH_CYCLES - 1);
                    pipeline_flush <= 1'b1;
                end
                FLUSH: if (cnt == 3'd0) begin
                    state          <= RUN;
                    pipeline_flush <= 1'b0;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_eco32f_wb.sv
// tb_eco32f_wb: scoreboard bench for eco32f_wb (default build plus a 4-cycle flush build)
module tb_eco32f_wb;
    logic clk = 1'b0, rst = 1'b1;
    logic stall = 0, valid = 0, load = 0, we = 0;
    logic [4:0] dst = '0;
    logic [31:0] alu = '0, lsu = '0, addr = '0, pc = '0;
    logic e_um = 0, e_km = 0, e_inv = 0, e_wr = 0, e_bus = 0;
    logic rf_we, exc, umiss, flush;
    logic [4:0] rf_dst, exc_code;
    logic [31:0] rf_result, exc_pc, bad_addr;
    logic rf_we4, exc4, umiss4, flush4;
    logic [4:0] rf_dst4, exc_code4;
    logic [31:0] rf_result4, exc_pc4, bad_addr4;
    int n_vec = 0, n_err = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  dst;
        logic [31:0] res;
        logic        exc;
        logic [4:0]  code;
        logic        um;
        logic [31:0] pc;
        logic [31:0] bad;
        logic        fl;
        logic        fl4;
    } exp_t;
    exp_t m = '0;
    exp_t sb[$];
    logic fl_cur[2] = '{1'b0, 1'b0};
    int rem[2] = '{0, 0};

    always #5 clk = ~clk;

    eco32f_wb u_dut (
        .clk(clk), .rst(rst), .mem_stall(stall), .mem_valid(valid), .mem_op_load(load),
        .mem_rf_we(we), .mem_rf_dst(dst), .mem_alu_result(alu), .mem_lsu_result(lsu),
        .mem_lsu_addr(addr), .mem_pc(pc), .mem_exc_dtlb_umiss(e_um), .mem_exc_dtlb_kmiss(e_km),
        .mem_exc_dtlb_invalid(e_inv), .mem_exc_dtlb_write(e_wr), .mem_exc_bus(e_bus),
        .wb_rf_we(rf_we), .wb_rf_dst(rf_dst), .wb_rf_result(rf_result), .wb_exc(exc),
        .wb_exc_code(exc_code), .wb_exc_umiss(umiss), .wb_exc_pc(exc_pc),
        .wb_bad_addr(bad_addr), .pipeline_flush(flush)
    );

    eco32f_wb #(.FLUSH_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .mem_stall(stall), .mem_valid(valid), .mem_op_load(load),
        .mem_rf_we(we), .mem_rf_dst(dst), .mem_alu_result(alu), .mem_lsu_result(lsu),
        .mem_lsu_addr(addr), .mem_pc(pc), .mem_exc_dtlb_umiss(e_um), .mem_exc_dtlb_kmiss(e_km),
        .mem_exc_dtlb_invalid(e_inv), .mem_exc_dtlb_write(e_wr), .mem_exc_bus(e_bus),
        .wb_rf_we(rf_we4), .wb_rf_dst(rf_dst4), .wb_rf_result(rf_result4), .wb_exc(exc4),
        .wb_exc_code(exc_code4), .wb_exc_umiss(umiss4), .wb_exc_pc(exc_pc4),
        .wb_bad_addr(bad_addr4), .pipeline_flush(flush4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // predict the next-cycle outputs from the current inputs, then clock and compare
    task automatic tick();
        exp_t e;
        logic ex, valid_slot;
        int n;
        e = m;
        ex = e_um || e_km || e_inv || e_wr || e_bus;
        valid_slot = !stall && valid;
        if (rst) begin
            e = '0;
            fl_cur = '{1'b0, 1'b0};
            rem = '{0, 0};
        end else begin
            e.we = valid_slot && !fl_cur[0] && !ex && we && dst != 0;
            e.exc = valid_slot && !fl_cur[0] && ex;
            if (valid_slot && !fl_cur[0] && !ex) begin
                e.dst = dst;
                e.res = load ? lsu : alu;
            end
            if (e.exc) begin
                e.um = 1'b0;
                if (e_bus) e.code = 16;
                else if (e_km) e.code = 21;
                else if (e_um) begin e.code = 21; e.um = 1'b1; end
                else if (e_wr) e.code = 22;
                else e.code = 23;
                e.pc = pc;
                e.bad = addr;
            end
            for (int i = 0; i < 2; i++) begin
                n = (i == 0) ? 2 : 4;
                if (valid_slot && !fl_cur[i] && ex) begin
                    fl_cur[i] = 1'b1;
                    rem[i] = n - 1;
                end else if (rem[i] > 0) begin
                    fl_cur[i] = 1'b1;
                    rem[i]--;
                end else fl_cur[i] = 1'b0;
            end
        end
        e.fl = fl_cur[0];
        e.fl4 = fl_cur[1];
        m = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("rf_we", 32'(rf_we), 32'(e.we));
        check("rf_dst", 32'(rf_dst), 32'(e.dst));
        check("rf_result", rf_result, e.res);
        check("exc", 32'(exc), 32'(e.exc));
        check("exc_code", 32'(exc_code), 32'(e.code));
        check("exc_umiss", 32'(umiss), 32'(e.um));
        check("exc_pc", exc_pc, e.pc);
        check("bad_addr", bad_addr, e.bad);
        check("flush", 32'(flush), 32'(e.fl));
        check("flush4", 32'(flush4), 32'(e.fl4));
    endtask

    task automatic op(input logic v, input logic ld, input logic w, input logic [4:0] d,
                      input logic [31:0] a, input logic [31:0] l);
        valid = v; load = ld; we = w; dst = d; alu = a; lsu = l;
        {e_bus, e_km, e_um, e_wr, e_inv} = '0;
    endtask

    task automatic fault(input logic [4:0] f, input logic [31:0] p, input logic [31:0] ad);
        valid = 1; we = 1; dst = 5'd3; alu = 32'h1111; pc = p; addr = ad;
        {e_bus, e_km, e_um, e_wr, e_inv} = f;
    endtask

    task automatic idle(input int n);
        op(0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        int flush_run;
        tick();
        tick();
        rst = 0;
        idle(1);
        op(1, 1, 1, 5'd5, 32'h1234, 32'hDEADBEEF); tick();
        op(1, 0, 1, 5'd7, 32'h0000A5A5, 32'hFFFF0000); tick();
        op(1, 0, 1, 5'd0, 32'h55, 32'h66); tick();
        op(1, 0, 1, 5'd9, 32'h99, 32'h0); stall = 1; tick(); tick();
        stall = 0;
        op(0, 0, 1, 5'd4, 32'h44, 32'h0); {e_bus, e_km} = 2'b11; tick();
        fault(5'b01000, 32'h100, 32'h200); stall = 1; tick();
        stall = 0;
        fault(5'b01001, 32'hC0001000, 32'h00400008); tick();
        fault(5'b10000, 32'hBAD0, 32'hBAD1);
        flush_run = 0;
        repeat (3) begin tick(); if (flush) flush_run++; end
        check("flush_len2", 32'(flush_run), 32'd2);
        idle(3);
        fault(5'b10100, 32'h2000, 32'h2004); tick(); idle(5);
        fault(5'b00100, 32'h3000, 32'h3004); tick();
        flush_run = 1;
        op(1, 0, 1, 5'd8, 32'h88, 32'h0);
        repeat (5) begin tick(); if (flush4) flush_run++; end
        check("flush_len4", 32'(flush_run), 32'd4);
        fault(5'b00010, 32'h4000, 32'h4004); tick(); idle(5);
        fault(5'b00001, 32'h5000, 32'h5004); tick(); idle(5);
        fault(5'b01000, 32'h6000, 32'h6004); tick();
        rst = 1; op(1, 0, 1, 5'd2, 32'h22, 32'h0); tick();
        rst = 0; idle(2);
        repeat (300) begin
            stall = ($urandom_range(0, 3) == 0);
            valid = $urandom_range(0, 1);
            load = $urandom_range(0, 1);
            we = $urandom_range(0, 1);
            dst = 5'($urandom_range(0, 3));
            alu = $urandom; lsu = $urandom; addr = $urandom; pc = $urandom;
            {e_bus, e_km, e_um, e_wr, e_inv} = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            rst = ($urandom_range(0, 40) == 0);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
